des_key_schedule: RTL and testbench

//  Iterative DES subkey generator, encrypt and decrypt direction. Loads a 64-bit key, applies PC-1,

---
 rtl/des_pkg.sv | 62 ++++++
 rtl/des_pc2.sv | 15 +
 rtl/des_key_schedule.sv | 104 ++++++++++
 tb/tb_des_key_schedule.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants, types and bit-permutation helpers (DES bit 1 = MSB).
package des_pkg;

    localparam int NUM_ROUNDS = 16;

    typedef logic [27:0] half_t;
    typedef logic [47:0] subkey_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_SCHED [NUM_ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Table entries are 1-based DES bit numbers counted from the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = key[64-PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic subkey_t pc2(input logic [55:0] cd);
        subkey_t r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2_TAB[i]];
        end
        return r;
    endfunction

    function automatic half_t rot(input half_t h, input int n, input logic right);
        half_t r;
        if (right) r = (h >> n) | (h << (28 - n));
        else       r = (h << n) | (h >> (28 - n));
        return r;
    endfunction

    // DES keys use odd parity per byte; any even-parity byte flags the key.
    function automatic logic key_parity_bad(input logic [63:0] key);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (!(^key[8*b +: 8])) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Purpose: PC-2 compression of the 56-bit C/D state into a 48-bit subkey.
// Latency: combinational, zero cycles.
// Backpressure: none; pure wiring.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output subkey_t     subkey
);

    always_comb begin
        subkey = pc2(cd);
    end

endmodule

// File: rtl/des_key_schedule.sv
// Purpose: iterative DES subkey generator, K1..K16 (encrypt) or K16..K1 (decrypt).
// Latency: first subkey the cycle after start; one subkey per accepted handshake, done one cycle after the last.
// Backpressure: subkey_valid held with C/D frozen until subkey_ready; optional DES_KEY_PARITY_CHECK_EN adds a key parity flag.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output subkey_t     subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic        parity_err
);

    state_t      state;
    half_t       c, d;
    logic [3:0]  cnt;
    logic        dec_q;
    logic [55:0] cd_load;
    logic [3:0]  sched_idx;
    int          shift_amt;
    logic        hs;

    assign cd_load = pc1(key_in);
    assign hs      = subkey_valid & subkey_ready;

    // Decrypt walks the schedule backwards, so it undoes the shift of the current round.
    always_comb begin
        sched_idx = dec_q ? (4'd15 - cnt) : (cnt + 4'd1);
        shift_amt = SHIFT_SCHED[sched_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            c            <= '0;
            d            <= '0;
            cnt          <= '0;
            dec_q        <= 1'b0;
            subkey_valid <= 1'b0;
            round_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // C16/D16 equal C0/D0, so decrypt loads unrotated; encrypt applies the K1 shift.
                        c            <= decrypt ? cd_load[55:28] : rot(cd_load[55:28], 1, 1'b0);
                        d            <= decrypt ? cd_load[27:0]  : rot(cd_load[27:0],  1, 1'b0);
                        dec_q        <= decrypt;
                        cnt          <= '0;
                        round_idx    <= decrypt ? 4'd15 : 4'd0;
                        subkey_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        cnt       <= cnt + 4'd1;
                        c         <= rot(c, shift_amt, dec_q);
                        d         <= rot(d, shift_amt, dec_q);
                        round_idx <= dec_q ? (4'd14 - cnt) : (cnt + 4'd1);
                        if (cnt == 4'd15) begin
                            subkey_valid <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            round_idx    <= '0;
                            state        <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c, d}),
        .subkey (subkey)
    );

`ifdef DES_KEY_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (state == IDLE && start) begin
            parity_err <= key_parity_bad(key_in);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomised bench for des_key_schedule against a cumulative-shift DES key-schedule model.
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SCH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        subkey_ready = 1'b0;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
    logic        parity_err;

    des_key_schedule dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Model: Kr = PC2 of C0/D0 each rotated left by the running total of shifts.
    function automatic logic [47:0] model_k(input logic [63:0] key, input int r);
        logic [27:0] c, d;
        logic [55:0] t, cd;
        logic [47:0] k;
        int s;
        s = 0;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = key[64-PC1_T[i]];
            d[27-i] = key[64-PC1_T[28+i]];
        end
        for (int i = 0; i < r; i++) s += SCH_T[i];
        t = {c, c} << s; c = t[55:28];
        t = {d, d} << s; d = t[55:28];
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
        return k;
    endfunction

    function automatic logic exp_par(input logic [63:0] key);
        logic bad;
        bad = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
        for (int b = 0; b < 8; b++) if ((^key[8*b +: 8]) == 1'b0) bad = 1'b1;
`endif
        return bad;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    bit          mon_en = 1'b0;
    bit          mon_dec = 1'b0;
    logic [47:0] mk [16];
    logic [47:0] got [2][16];
    int          hs_n = 0, done_n = 0, done_cyc = 0, first_cyc = -1, start_cyc = 0, mon_er = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (subkey_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (hs_n < 16) begin
                    mon_er = mon_dec ? 15 - hs_n : hs_n;
                    chk("round_idx", 64'(round_idx), 64'(mon_er));
                    chk("subkey", 64'(subkey), 64'(mk[mon_er]));
                    chk("busy_while_valid", 64'(busy), 64'd1);
                    if (subkey_ready) got[mon_dec][hs_n] = subkey;
                end else begin
                    chk("valid_after_16", 64'(subkey_valid), 64'd0);
                end
                if (subkey_ready) hs_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_run(input logic [63:0] key, input logic dec);
        @(posedge clk); #1;
        for (int r = 0; r < 16; r++) mk[r] = model_k(key, r + 1);
        hs_n = 0; done_n = 0; first_cyc = -1;
        mon_dec = dec; mon_en = 1'b1;
        start = 1'b1; key_in = key; decrypt = dec;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        key_in = {$urandom, $urandom};
        decrypt = ~dec;
        chk("parity_err", 64'(parity_err), 64'(exp_par(key)));
    endtask

    // mode 0: ready high; 1: random ready; 2: random plus 20-cycle stall at round 7.
    // inj 1: foreign start mid-run; inj 2: start held across last handshake and DONE.
    task automatic drive(input int mode, input int inj);
        int budget, stall;
        budget = 0; stall = 0;
        while (done_n == 0 && budget < 400) begin
            case (mode)
                0: subkey_ready = 1'b1;
                1: subkey_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (hs_n == 7 && stall < 20) begin
                        subkey_ready = 1'b0;
                        stall++;
                    end else begin
                        subkey_ready = 1'($urandom_range(0, 1));
                    end
                end
            endcase
            if (inj == 1) start = (hs_n == 3);
            else if (inj == 2) start = (hs_n >= 15);
            if (start) key_in = {$urandom, $urandom};
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        subkey_ready = 1'b0;
        if (budget >= 400) chk("run_timeout", 64'(budget), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("handshakes", 64'(hs_n), 64'd16);
        chk("done_pulses", 64'(done_n), 64'd1);
        chk("idle_valid", 64'(subkey_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        logic [63:0] k;
        int budget;

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_round_idx", 64'(round_idx), 64'd0);
        chk("rst_parity_err", 64'(parity_err), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        chk("model_k1", 64'(model_k(FIPS_KEY, 1)), 64'h1B02EFFC7072);
        chk("model_k16", 64'(model_k(FIPS_KEY, 16)), 64'hCB3D8B0E17F5);

        // FIPS encrypt, back-to-back timing
        start_run(FIPS_KEY, 1'b0);
        chk("fips_k1_literal", 64'(subkey), 64'h1B02EFFC7072);
        drive(0, 0);
        chk("first_valid_cycle", 64'(first_cyc - start_cyc), 64'd1);
        chk("done_cycle", 64'(done_cyc - start_cyc), 64'd17);
        chk("fips_k16_captured", 64'(got[0][15]), 64'hCB3D8B0E17F5);

        // FIPS decrypt with start colliding with last handshake and DONE
        start_run(FIPS_KEY, 1'b1);
        chk("fips_dec_first", 64'(subkey), 64'hCB3D8B0E17F5);
        chk("fips_dec_first_idx", 64'(round_idx), 64'd15);
        drive(0, 2);
        chk("fips_dec_last", 64'(got[1][15]), 64'h1B02EFFC7072);

        // Random keys: enc and dec streams must mirror
        for (int n = 0; n < 3; n++) begin
            k = {$urandom, $urandom};
            start_run(k, 1'b0);
            drive(1, 0);
            start_run(k, 1'b1);
            drive(1, 0);
            for (int i = 0; i < 16; i++) chk("dec_is_reversed_enc", 64'(got[1][i]), 64'(got[0][15-i]));
        end

        start_run({$urandom, $urandom}, 1'b0);
        drive(2, 0);
        start_run({$urandom, $urandom}, 1'b1);
        drive(1, 1);

        // Async reset in round 5
        start_run({$urandom, $urandom}, 1'b0);
        subkey_ready = 1'b1;
        budget = 0;
        while (hs_n < 5 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        subkey_ready = 1'b0;
        if (budget >= 100) chk("reset_run_timeout", 64'(budget), 64'd0);
        #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(subkey_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_round_idx", 64'(round_idx), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("async_rst_no_done", 64'(done), 64'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        start_run({$urandom, $urandom}, 1'b1);
        drive(1, 0);

        // Parity: all-zero key has even parity bytes; 0x01 bytes are odd
        start_run(64'h0000000000000000, 1'b0);
        drive(0, 0);
        start_run(64'h0101010101010101, 1'b0);
        drive(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
